cpu_core_mc: RTL and testbench

- Parametrised multicycle CPU core. It is the next generation of the single-cycle 8-bit CPU.
- Sequences instructions with a FETCH/EXEC/MEM/HALT state machine.
- Keeps a full NZCV flag register.
- Accesses data memory through a req/ready handshake so that slow or multi-cycle RAM can stall it.
- Instantiated by the top level in place of the discrete PC, control unit, ALU and register file. ROM, RAM and display stay outside.

---
 rtl/cpu_core_mc.sv | 171 +++++++++++++++++
 tb/tb_cpu_core_mc.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_core_mc.sv
// Multicycle CPU core: FETCH/EXEC/MEM/HALT sequencer, NZCV flags and a
// req/ready data-memory port that lets slow RAM stall the core.
module cpu_core_mc #(
   parameter int DATA_W  = 8,
   parameter int PC_W    = 8,
   parameter int DADDR_W = 8,
   parameter int NREGS   = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [PC_W-1:0]    start_addr,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [15:0]        imem_data,
   output logic               dmem_req,
   output logic               dmem_we,
   output logic [DADDR_W-1:0] dmem_addr,
   output logic [DATA_W-1:0]  dmem_wdata,
   input  logic [DATA_W-1:0]  dmem_rdata,
   input  logic               dmem_ready,
   output logic [PC_W-1:0]    pc,
   output logic [3:0]         flags,
   output logic               halted,
   output logic               illegal
);

   localparam int         MSB     = DATA_W - 1;
   localparam logic [3:0] NREGS_L = 4'(NREGS);

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ADD  = 4'h1;
   localparam logic [3:0] OP_SUB  = 4'h2;
   localparam logic [3:0] OP_AND  = 4'h3;
   localparam logic [3:0] OP_OR   = 4'h4;
   localparam logic [3:0] OP_XOR  = 4'h5;
   localparam logic [3:0] OP_LDI  = 4'h6;
   localparam logic [3:0] OP_LD   = 4'h7;
   localparam logic [3:0] OP_ST   = 4'h8;
   localparam logic [3:0] OP_CMP  = 4'h9;
   localparam logic [3:0] OP_JMP  = 4'hA;
   localparam logic [3:0] OP_BLT  = 4'hB;
   localparam logic [3:0] OP_BEQ  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hD;

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

   state_t            state;
   logic [15:0]       ir;
   // Always 8 entries so 3-bit fields index directly; entries >= NREGS stay 0.
   logic [DATA_W-1:0] regs [8];

   logic [3:0]        op;
   logic [2:0]        rd, rs1, rs2;
   logic              rd_ok;
   logic [DATA_W-1:0] a, b, d;
   logic [DATA_W-1:0] imm_d;
   logic [PC_W-1:0]   imm_pc, pc_inc;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c, alu_v;
   logic [3:0]        alu_flags;
   logic              taken;

   assign op     = ir[15:12];
   assign rd     = ir[11:9];
   assign rs1    = ir[8:6];
   assign rs2    = ir[5:3];
   assign rd_ok  = {1'b0, rd} < NREGS_L;
   assign a      = ({1'b0, rs1} < NREGS_L) ? regs[rs1] : '0;
   assign b      = ({1'b0, rs2} < NREGS_L) ? regs[rs2] : '0;
   assign d      = rd_ok ? regs[rd] : '0;
   assign imm_d  = DATA_W'(ir[7:0]);
   assign imm_pc = PC_W'(ir[7:0]);
   assign pc_inc = pc + PC_W'(1);

   assign imem_addr = pc;

   always_comb begin
      sum     = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      case (op)
         OP_ADD: begin
            sum     = {1'b0, a} + {1'b0, b};
            alu_res = sum[MSB:0];
            alu_c   = sum[DATA_W];
            alu_v   = (a[MSB] == b[MSB]) && (alu_res[MSB] != a[MSB]);
         end
         OP_SUB, OP_CMP: begin
            // Borrow lands in the extra bit; C is the inverted borrow.
            sum     = {1'b0, a} - {1'b0, b};
            alu_res = sum[MSB:0];
            alu_c   = ~sum[DATA_W];
            alu_v   = (a[MSB] != b[MSB]) && (alu_res[MSB] != a[MSB]);
         end
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_XOR:  alu_res = a ^ b;
         default: alu_res = '0;
      endcase
   end

   assign alu_flags = {alu_res[MSB], alu_res == '0, alu_c, alu_v};

   // Branches look at the flags held before this instruction.
   assign taken = (op == OP_JMP) ||
                  ((op == OP_BLT) && (flags[3] ^ flags[0])) ||
                  ((op == OP_BEQ) && flags[2]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_FETCH;
         pc         <= start_addr;
         ir         <= '0;
         flags      <= '0;
         dmem_req   <= 1'b0;
         dmem_we    <= 1'b0;
         dmem_addr  <= '0;
         dmem_wdata <= '0;
         halted     <= 1'b0;
         illegal    <= 1'b0;
         for (int i = 0; i < 8; i++) regs[i] <= '0;
      end else begin
         illegal <= 1'b0;
         case (state)
            S_FETCH: begin
               ir    <= imem_data;
               state <= S_EXEC;
            end
            S_EXEC: begin
               pc    <= taken ? imm_pc : pc_inc;
               state <= S_FETCH;
               case (op)
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
                     if (rd_ok) regs[rd] <= alu_res;
                     flags <= alu_flags;
                  end
                  OP_CMP: flags <= alu_flags;
                  OP_LDI: if (rd_ok) regs[rd] <= imm_d;
                  OP_LD, OP_ST: begin
                     // pc holds the instruction address until the access completes.
                     pc         <= pc;
                     dmem_req   <= 1'b1;
                     dmem_we    <= (op == OP_ST);
                     dmem_addr  <= DADDR_W'(ir[7:0]);
                     dmem_wdata <= d;
                     state      <= S_MEM;
                  end
                  OP_HALT: begin
                     halted <= 1'b1;
                     state  <= S_HALT;
                  end
                  4'hE, 4'hF: illegal <= 1'b1;
                  default: ;
               endcase
            end
            S_MEM: begin
               if (dmem_ready) begin
                  if (!dmem_we && rd_ok) regs[rd] <= dmem_rdata;
                  dmem_req <= 1'b0;
                  pc       <= pc_inc;
                  state    <= S_FETCH;
               end
            end
            S_HALT: ;
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_core_mc.sv
// Scoreboard bench for cpu_core_mc: an ISA-level model predicts memory
// transactions and final state; a monitor checks the DUT's memory port.
module tb_cpu_core_mc;

   localparam int NR = 6;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  start_addr = '0;
   logic [7:0]  imem_addr;
   logic [15:0] imem_data;
   logic        dmem_req, dmem_we;
   logic [7:0]  dmem_addr, dmem_wdata;
   logic [7:0]  dmem_rdata;
   logic        dmem_ready;
   logic [7:0]  pc;
   logic [3:0]  flags;
   logic        halted, illegal;

   always #5 clk = ~clk;

   logic [15:0] rom  [256];
   logic [7:0]  ram  [256];
   logic [7:0]  mref [256];

   assign imem_data = rom[imem_addr];

   cpu_core_mc #(.DATA_W(8), .PC_W(8), .DADDR_W(8), .NREGS(NR)) dut (
      .clk(clk), .reset(reset), .start_addr(start_addr),
      .imem_addr(imem_addr), .imem_data(imem_data),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
      .pc(pc), .flags(flags), .halted(halted), .illegal(illegal)
   );

   typedef struct packed {
      logic       we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] pc;
   } txn_t;

   txn_t       exp_q[$];
   int         n_checks = 0;
   int         n_fail = 0;
   int         exp_ill = 0;
   int         ill_cnt = 0;
   int         cur_req_cycles = 0;
   int         last_req_cycles = 0;
   logic [7:0] exp_pc = '0;
   logic [3:0] exp_flags = '0;
   bit         stall = 1'b0;
   int         force_wait = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] enc(input int op, input int rd, input int ra, input int rb);
      return {4'(op), 3'(rd), 3'(ra), 3'(rb), 3'b000};
   endfunction

   function automatic logic [15:0] enci(input int op, input int rd, input int imm);
      return {4'(op), 3'(rd), 1'b0, 8'(imm)};
   endfunction

   function automatic int sx(input int x);
      return (x > 127) ? x - 256 : x;
   endfunction

   // Instruction-level reference: runs the program to HALT on plain ints.
   task automatic model(input logic [7:0] s);
      int r[8];
      int n, z, c, v, p, np, op, rd, ra, rb, imm, a, b, dv, res, sv;
      bit upd, wr;
      logic [15:0] ins;
      for (int i = 0; i < 8; i++) r[i] = 0;
      n = 0; z = 0; c = 0; v = 0; p = int'(s); exp_ill = 0;
      for (int step = 0; step < 5000; step++) begin
         ins = rom[p];
         op = int'(ins[15:12]); rd = int'(ins[11:9]); ra = int'(ins[8:6]);
         rb = int'(ins[5:3]); imm = int'(ins[7:0]);
         a  = (ra < NR) ? r[ra] : 0;
         b  = (rb < NR) ? r[rb] : 0;
         dv = (rd < NR) ? r[rd] : 0;
         np = (p + 1) % 256;
         upd = 0; wr = 0; res = 0;
         case (op)
            1: begin res = a + b; c = (res > 255); sv = sx(a) + sx(b);
                     v = (sv > 127 || sv < -128); upd = 1; wr = 1; end
            2, 9: begin res = a - b; c = (a >= b); sv = sx(a) - sx(b);
                     v = (sv > 127 || sv < -128); upd = 1; wr = (op == 2); end
            3: begin res = a & b; c = 0; v = 0; upd = 1; wr = 1; end
            4: begin res = a | b; c = 0; v = 0; upd = 1; wr = 1; end
            5: begin res = a ^ b; c = 0; v = 0; upd = 1; wr = 1; end
            6: begin res = imm; wr = 1; end
            7: begin exp_q.push_back('{we: 1'b0, addr: 8'(imm), wdata: 8'(dv), pc: 8'(p)});
                     res = int'(mref[imm]); wr = 1; end
            8: begin exp_q.push_back('{we: 1'b1, addr: 8'(imm), wdata: 8'(dv), pc: 8'(p)});
                     mref[imm] = 8'(dv); end
            10: np = imm;
            11: if (n != v) np = imm;
            12: if (z != 0) np = imm;
            13: begin exp_pc = 8'(np); exp_flags = {1'(n), 1'(z), 1'(c), 1'(v)}; return; end
            14, 15: exp_ill++;
            default: ;
         endcase
         res = res & 255;
         if (upd) begin n = (res >= 128); z = (res == 0); end
         if (wr && rd < NR) r[rd] = res;
         p = np;
      end
   endtask

   // RAM responder: random wait states, random ready outside requests.
   initial begin : responder
      int  wcnt;
      bit  busy;
      wcnt = 0; busy = 0;
      dmem_ready = 1'b0; dmem_rdata = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            dmem_ready = 1'b0; busy = 0;
         end else if (!dmem_req) begin
            dmem_ready = 1'($urandom_range(0, 1)); dmem_rdata = 8'($urandom); busy = 0;
         end else if (stall) begin
            dmem_ready = 1'b0;
         end else begin
            if (!busy) begin
               busy = 1;
               wcnt = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 3));
            end
            if (wcnt == 0) begin
               dmem_ready = 1'b1;
               dmem_rdata = ram[dmem_addr];
               if (dmem_we) ram[dmem_addr] = dmem_wdata;
            end else begin
               dmem_ready = 1'b0;
               wcnt--;
            end
         end
      end
   end

   // Monitor: every request cycle must match the head of the scoreboard.
   always @(negedge clk) begin
      if (reset) begin
         cur_req_cycles = 0;
      end else begin
         if (illegal) ill_cnt++;
         if (dmem_req) begin
            cur_req_cycles++;
            if (exp_q.size() == 0) begin
               n_checks++; n_fail++;
               $display("FAIL unexpected_req: addr 0x%0h we %0d with empty scoreboard", dmem_addr, dmem_we);
            end else begin
               chk("req_we", dmem_we, exp_q[0].we);
               chk("req_addr", dmem_addr, exp_q[0].addr);
               if (exp_q[0].we) chk("req_wdata", dmem_wdata, exp_q[0].wdata);
               chk("req_pc", pc, exp_q[0].pc);
               if (dmem_ready) begin
                  void'(exp_q.pop_front());
                  last_req_cycles = cur_req_cycles;
                  cur_req_cycles = 0;
               end
            end
         end
      end
   end

   task automatic fill(input logic [15:0] w);
      for (int i = 0; i < 256; i++) begin rom[i] = w; ram[i] = 8'($urandom); end
   endtask

   task automatic prog_start(input logic [7:0] s);
      @(negedge clk);
      reset = 1'b1; start_addr = s;
      exp_q.delete();
      for (int i = 0; i < 256; i++) mref[i] = ram[i];
      model(s);
      repeat (2) @(negedge clk);
      ill_cnt = 0;
      reset = 1'b0;
   endtask

   task automatic prog_finish(input string tag);
      for (int i = 0; i < 1000 && !halted; i++) @(negedge clk);
      chk({tag, "_halt_reached"}, halted, 1);
      chk({tag, "_pc"}, pc, exp_pc);
      chk({tag, "_flags"}, flags, exp_flags);
      chk({tag, "_txn_left"}, exp_q.size(), 0);
      chk({tag, "_illegal_cnt"}, ill_cnt, exp_ill);
   endtask

   task automatic gen_rand(output logic [7:0] s);
      int base, endp, pick, addr;
      base = int'($urandom_range(0, 96));
      endp = base + 24;
      fill(16'hD000);
      for (int k = 0; k < 24; k++) begin
         addr = base + k;
         pick = int'($urandom_range(0, 14));
         case (pick)
            0: rom[addr] = 16'h0000;
            1, 2, 3, 4, 5, 6: rom[addr] = enc(pick, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7));
            7, 8: rom[addr] = enci(6, $urandom_range(0, 7), $urandom_range(0, 255));
            9: rom[addr] = enci(7, $urandom_range(0, 7), $urandom_range(0, 239));
            10: rom[addr] = enci(8, $urandom_range(0, 7), $urandom_range(0, 239));
            11, 12, 13: rom[addr] = enci(pick - 1, 0, $urandom_range(addr + 1, endp));
            default: rom[addr] = {4'($urandom_range(14, 15)), 12'($urandom)};
         endcase
         if (pick == 6) rom[addr] = enc(9, 0, $urandom_range(0, 7), $urandom_range(0, 7));
      end
      for (int i = 0; i < 8; i++) rom[endp + i] = enci(8, i, 240 + i);
      rom[endp + 8] = 16'hD000;
      s = 8'(base);
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stim
      logic [7:0] s;
      int i;

      // Reset state and ADD overflow with exact instruction latency.
      fill(16'hD000);
      rom[8'h05] = enci(6, 1, 8'h7F);
      rom[8'h06] = enci(6, 2, 8'h01);
      rom[8'h07] = enc(1, 3, 1, 2);
      rom[8'h08] = enci(8, 3, 8'h40);
      prog_start(8'h05);
      chk("rst_pc", pc, 8'h05);
      chk("rst_imem_addr", imem_addr, 8'h05);
      chk("rst_flags", flags, 4'b0000);
      chk("rst_halted", halted, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_illegal", illegal, 0);
      repeat (4) @(posedge clk); #1;
      chk("add_pre_flags", flags, 4'b0000);
      chk("add_pre_pc", pc, 8'h07);
      repeat (2) @(posedge clk); #1;
      chk("add_flags", flags, 4'b1001);
      chk("add_pc", pc, 8'h08);
      prog_finish("add");

      // BLT taken (3 < 5) then not taken (5 < 3 false).
      fill(16'hD000);
      rom[0] = enci(6, 1, 3); rom[1] = enci(6, 2, 5);
      rom[2] = enc(9, 0, 1, 2); rom[3] = enci(11, 0, 8'h20);
      prog_start(8'h00);
      repeat (8) @(posedge clk); #1;
      chk("blt_taken_pc", pc, 8'h20);
      prog_finish("blt_taken");
      rom[0] = enci(6, 1, 5); rom[1] = enci(6, 2, 3);
      prog_start(8'h00);
      repeat (6) @(posedge clk); #1;
      chk("cmp_flags", flags, 4'b0010);
      repeat (2) @(posedge clk); #1;
      chk("blt_not_taken_pc", pc, 8'h04);
      prog_finish("blt_not");

      // Store with three wait cycles: request held four cycles.
      fill(16'hD000);
      rom[0] = enci(6, 4, 8'hA5); rom[1] = enci(8, 4, 8'h10);
      force_wait = 3;
      prog_start(8'h00);
      prog_finish("st_wait");
      chk("st_req_cycles", last_req_cycles, 4);
      chk("st_ram", ram[8'h10], 8'hA5);
      force_wait = -1;

      // Load, then reset while the load is stalled in MEM.
      fill(16'hD000);
      ram[8'h10] = 8'h3C;
      rom[8'h30] = enci(7, 5, 8'h10); rom[8'h31] = enci(8, 5, 8'h41);
      prog_start(8'h30);
      prog_finish("ld");
      chk("ld_stored", ram[8'h41], 8'h3C);
      stall = 1'b1;
      prog_start(8'h30);
      for (i = 0; i < 20 && !dmem_req; i++) @(negedge clk);
      chk("stall_req_seen", dmem_req, 1);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_mem_req_drop", dmem_req, 0);
      chk("rst_mem_pc", pc, 8'h30);
      stall = 1'b0;
      prog_start(8'h30);
      prog_finish("ld_rerun");

      // Illegal opcode then HALT; pc frozen afterwards.
      fill(16'hD000);
      rom[8'h40] = 16'hE123;
      prog_start(8'h40);
      prog_finish("ill");
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("halt_pc_frozen", pc, exp_pc);
         chk("halt_held", halted, 1);
      end

      // pc wraps from 0xFF to 0x00.
      fill(16'hD000);
      rom[8'hFF] = 16'h0000;
      prog_start(8'hFF);
      repeat (2) @(posedge clk); #1;
      chk("wrap_pc", pc, 8'h00);
      prog_finish("wrap");

      // Random programs against the model.
      for (int t = 0; t < 20; t++) begin
         gen_rand(s);
         prog_start(s);
         prog_finish("rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
